// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - bus bundle between the core and the microcode sequencer
// Purpose: groups instruction/flag inputs, sequencing controls, the microcode
// write port and the control/status outputs of microcode_sequencer.
// Modports:
//   master - core side: drives i_* signals, observes o_* signals
//   slave  - sequencer side: observes i_* signals, drives o_* signals
// Word width UW grows by one PAR bit when MICROCODE_SEQUENCER_PARITY_EN is defined.
interface microcode_sequencer_if #(
    parameter int INSTRUCTION_WIDTH  = 16,
    parameter int OPCODE_BITS        = 6,
    parameter int INSTRUCTION_STEPS  = 32,
    parameter int CONTROL_WORD_WIDTH = 32,
    parameter int FLAG_COUNT         = 3
);
    localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS);
    localparam int FSW        = ($clog2(FLAG_COUNT) > 1) ? $clog2(FLAG_COUNT) : 1;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    localparam int UW = CONTROL_WORD_WIDTH + 4 + FSW + 1;
`else
    localparam int UW = CONTROL_WORD_WIDTH + 4 + FSW;
`endif

    logic [INSTRUCTION_WIDTH-1:0]      i_instruction;
    logic [FLAG_COUNT-1:0]             i_flags;
    logic                              i_stall;
    logic                              i_resume;
    logic                              i_ucode_we;
    logic [OPCODE_BITS+STEP_WIDTH-1:0] i_ucode_addr;
    logic [UW-1:0]                     i_ucode_data;
    logic [CONTROL_WORD_WIDTH-1:0]     o_control_word;
    logic [STEP_WIDTH-1:0]             o_step;
    logic                              o_halted;
    logic                              o_illegal;
    logic                              o_step_overflow;
    logic                              o_ucode_error;

    modport master (
        output i_instruction, i_flags, i_stall, i_resume,
        output i_ucode_we, i_ucode_addr, i_ucode_data,
        input  o_control_word, o_step, o_halted, o_illegal, o_step_overflow, o_ucode_error
    );

    modport slave (
        input  i_instruction, i_flags, i_stall, i_resume,
        input  i_ucode_we, i_ucode_addr, i_ucode_data,
        output o_control_word, o_step, o_halted, o_illegal, o_step_overflow, o_ucode_error
    );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - loadable-microcode step sequencer with halt, stall and traps
// Purpose: owns the step counter and a writable microcode store indexed by
// {opcode, step}; produces the core control word combinationally.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-high reset (RUN, step 0, outputs 0)
//   bus      - microcode_sequencer_if.slave: instruction, flags, stall, resume,
//              microcode write port, control word, step, halted, illegal,
//              step_overflow, ucode_error
// Optional feature: define MICROCODE_SEQUENCER_PARITY_EN to add an even-parity
// bit to each microcode word; a bad word halts the core and sets a sticky error.
// Word layout, LSB up: CTRL, END, HLT, COND, POL, SEL[FSW-1:0], PAR (parity build).
module microcode_sequencer #(
    parameter int INSTRUCTION_WIDTH  = 16,
    parameter int OPCODE_BITS        = 6,
    parameter int INSTRUCTION_STEPS  = 32,
    parameter int CONTROL_WORD_WIDTH = 32,
    parameter int FLAG_COUNT         = 3,
    parameter logic [CONTROL_WORD_WIDTH-1:0] FETCH0_CW = '0,
    parameter logic [CONTROL_WORD_WIDTH-1:0] FETCH1_CW = '0
) (
    input logic                   i_clk,
    input logic                   i_reset,
    microcode_sequencer_if.slave  bus
);
    localparam int CW  = CONTROL_WORD_WIDTH;
    localparam int SW  = $clog2(INSTRUCTION_STEPS);
    localparam int FSW = ($clog2(FLAG_COUNT) > 1) ? $clog2(FLAG_COUNT) : 1;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    localparam int UW  = CW + 4 + FSW + 1;
`else
    localparam int UW  = CW + 4 + FSW;
`endif
    localparam int AW    = OPCODE_BITS + SW;
    localparam int DEPTH = 1 << AW;

    localparam int F_END  = CW;
    localparam int F_HLT  = CW + 1;
    localparam int F_COND = CW + 2;
    localparam int F_POL  = CW + 3;
    localparam int F_SEL  = CW + 4;

    localparam logic [SW-1:0] LAST_STEP = SW'(INSTRUCTION_STEPS - 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    logic [SW-1:0]   step;
    logic [UW-1:0]   store [0:DEPTH-1];

    logic [OPCODE_BITS-1:0] opcode;
    logic                   illegal_op;
    logic [UW-1:0]          word;
    logic [FSW-1:0]         sel;
    logic                   flag_bit;
    logic                   end_cond;

    logic [CW-1:0]          cw;
    logic                   illegal_pulse;
    logic                   overflow_pulse;
    logic                   end_instr;
    logic                   halt_req;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    logic                   par_bad;
    logic                   par_err;
    logic                   ucode_error;
`endif

    // Store has no reset: microcode survives a core reset.
    always_ff @(posedge i_clk) begin
        if (bus.i_ucode_we) begin
            store[bus.i_ucode_addr] <= bus.i_ucode_data;
        end
    end

    assign opcode     = bus.i_instruction[OPCODE_BITS-1:0];
    assign illegal_op = |bus.i_instruction[INSTRUCTION_WIDTH-1:OPCODE_BITS];
    assign word       = store[{opcode, step}];
    assign sel        = word[F_SEL +: FSW];
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    // Even parity across the whole word, PAR included, must come out zero.
    assign par_bad    = ^word;
`endif

    // Out-of-range selectors fall back to flag 0.
    always_comb begin
        flag_bit = bus.i_flags[0];
        for (int k = 1; k < FLAG_COUNT; k++) begin
            if (sel == FSW'(k)) begin
                flag_bit = bus.i_flags[k];
            end
        end
    end

    assign end_cond = word[F_END] | (word[F_COND] & (flag_bit == word[F_POL]));

    always_comb begin
        cw             = '0;
        illegal_pulse  = 1'b0;
        overflow_pulse = 1'b0;
        end_instr      = 1'b0;
        halt_req       = 1'b0;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
        par_err        = 1'b0;
`endif
        if (state == RUN && !bus.i_stall) begin
            if (step == SW'(0)) begin
                cw = FETCH0_CW;
            end else if (step == SW'(1)) begin
                cw = FETCH1_CW;
            end else if (illegal_op) begin
                // Illegal opcode executes as a one-step NOP; the store is not consulted.
                illegal_pulse = 1'b1;
                end_instr     = 1'b1;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
            end else if (par_bad) begin
                par_err  = 1'b1;
                halt_req = 1'b1;
`endif
            end else begin
                cw = word[CW-1:0];
                if (word[F_HLT]) begin
                    halt_req = 1'b1;
                end else if (end_cond) begin
                    end_instr = 1'b1;
                end else if (step == LAST_STEP) begin
                    overflow_pulse = 1'b1;
                    end_instr      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= RUN;
            step  <= '0;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
            ucode_error <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (!bus.i_stall) begin
                        if (halt_req) begin
                            state <= HALT;
                        end else if (end_instr) begin
                            step <= '0;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                HALT: begin
                    // Resume beats a simultaneous stall.
                    if (bus.i_resume) begin
                        state <= RUN;
                        step  <= '0;
                    end
                end
                default: state <= RUN;
            endcase
`ifdef MICROCODE_SEQUENCER_PARITY_EN
            if (par_err) begin
                ucode_error <= 1'b1;
            end
`endif
        end
    end

    // Combinational outputs are forced low for as long as reset is held.
    assign bus.o_control_word  = i_reset ? '0 : cw;
    assign bus.o_step          = step;
    assign bus.o_halted        = (state == HALT);
    assign bus.o_illegal       = illegal_pulse & ~i_reset;
    assign bus.o_step_overflow = overflow_pulse & ~i_reset;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    assign bus.o_ucode_error   = ucode_error;
`else
    assign bus.o_ucode_error   = 1'b0;
`endif
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - scoreboard testbench for microcode_sequencer
module tb_microcode_sequencer;
    localparam logic [31:0] FA = 32'hF0F0_0001;
    localparam logic [31:0] FB = 32'h0F0F_0002;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
    localparam int UW = 39;
`else
    localparam int UW = 38;
`endif

    typedef struct packed {
        logic [31:0] cw;
        logic [4:0]  st;
        logic        hl;
        logic        il;
        logic        ov;
        logic        er;
    } exp_t;

    logic clk;
    logic rst;

    exp_t  exp_q[$];
    string lbl_q[$];
    int    n_checks;
    int    n_fail;

    microcode_sequencer_if #(
        .INSTRUCTION_WIDTH(16), .OPCODE_BITS(6), .INSTRUCTION_STEPS(32),
        .CONTROL_WORD_WIDTH(32), .FLAG_COUNT(3)
    ) bus ();

    microcode_sequencer #(
        .INSTRUCTION_WIDTH(16), .OPCODE_BITS(6), .INSTRUCTION_STEPS(32),
        .CONTROL_WORD_WIDTH(32), .FLAG_COUNT(3),
        .FETCH0_CW(FA), .FETCH1_CW(FB)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [UW-1:0] mk(input logic [31:0] ctrl, input bit e, input bit h,
                                         input bit c, input bit p, input logic [1:0] sel);
        logic [UW-1:0] w;
        w = '0;
        w[31:0]  = ctrl;
        w[32]    = e;
        w[33]    = h;
        w[34]    = c;
        w[35]    = p;
        w[37:36] = sel;
`ifdef MICROCODE_SEQUENCER_PARITY_EN
        w[38] = ^w[37:0];
`endif
        return w;
    endfunction

    task automatic wr(input logic [5:0] op, input logic [4:0] st, input logic [UW-1:0] d);
        bus.i_ucode_we   = 1'b1;
        bus.i_ucode_addr = {op, st};
        bus.i_ucode_data = d;
        @(posedge clk); #1;
        bus.i_ucode_we   = 1'b0;
    endtask

    task automatic chk_full(input string lbl, input logic [31:0] cw, input int st,
                            input bit hl, input bit il, input bit ov, input bit er);
        exp_t e;
        e.cw = cw;
        e.st = 5'(st);
        e.hl = hl;
        e.il = il;
        e.ov = ov;
        e.er = er;
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        @(posedge clk); #1;
    endtask

    task automatic chk(input string lbl, input logic [31:0] cw, input int st);
        chk_full(lbl, cw, st, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            a.cw = bus.o_control_word;
            a.st = bus.o_step;
            a.hl = bus.o_halted;
            a.il = bus.o_illegal;
            a.ov = bus.o_step_overflow;
            a.er = bus.o_ucode_error;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got cw=%h step=%0d halted=%b illegal=%b ovf=%b err=%b, expected cw=%h step=%0d halted=%b illegal=%b ovf=%b err=%b",
                         l, a.cw, a.st, a.hl, a.il, a.ov, a.er, e.cw, e.st, e.hl, e.il, e.ov, e.er);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [UW-1:0] bad;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_instruction = '0;
        bus.i_flags       = '0;
        bus.i_stall       = 1'b0;
        bus.i_resume      = 1'b0;
        bus.i_ucode_we    = 1'b0;
        bus.i_ucode_addr  = '0;
        bus.i_ucode_data  = '0;
        @(posedge clk); #1;
        chk("reset_outputs", 32'h0, 0);

        // Load microcode while reset is held.
        wr(6'h01, 5'd2, mk(32'h5, 0, 0, 0, 0, 2'd0));
        wr(6'h01, 5'd3, mk(32'h9, 1, 0, 0, 0, 2'd0));
        wr(6'h2e, 5'd2, mk(32'h3, 0, 0, 1, 0, 2'd0));
        wr(6'h2e, 5'd3, mk(32'h77, 1, 0, 0, 0, 2'd0));
        for (int s = 2; s < 32; s++) wr(6'h3f, 5'(s), '0);
        wr(6'h05, 5'd2, mk(32'h11, 1, 1, 0, 0, 2'd0));
        wr(6'h06, 5'd2, mk(32'h21, 0, 0, 1, 1, 2'd3));
        wr(6'h06, 5'd3, mk(32'h22, 1, 0, 0, 0, 2'd0));
        wr(6'h07, 5'd2, mk(32'h31, 0, 0, 0, 0, 2'd0));
        wr(6'h07, 5'd3, mk(32'h32, 1, 0, 0, 0, 2'd0));
`ifdef MICROCODE_SEQUENCER_PARITY_EN
        bad = mk(32'h51, 1, 0, 0, 0, 2'd0);
        bad[UW-1] = ~bad[UW-1];
        wr(6'h08, 5'd2, bad);
`else
        bad = '0;
`endif
        rst = 1'b0;

        // Basic two-step instruction.
        bus.i_instruction = 16'h0001;
        chk("op01_s0", FA, 0);
        chk("op01_s1", FB, 1);
        chk("op01_s2", 32'h5, 2);
        chk("op01_s3", 32'h9, 3);

        // Conditional end on flag 0 == 0.
        bus.i_instruction = 16'h002e;
        bus.i_flags = 3'b001;
        chk("op2e_f1_s0", FA, 0);
        chk("op2e_f1_s1", FB, 1);
        chk("op2e_f1_s2", 32'h3, 2);
        chk("op2e_f1_s3", 32'h77, 3);
        bus.i_flags = 3'b000;
        chk("op2e_f0_s0", FA, 0);
        chk("op2e_f0_s1", FB, 1);
        chk("op2e_f0_s2", 32'h3, 2);

        // Illegal opcode.
        bus.i_instruction = 16'hffc0;
        chk("ill_s0", FA, 0);
        chk("ill_s1", FB, 1);
        chk_full("ill_s2", 32'h0, 2, 0, 1, 0, 0);

        // SEL beyond FLAG_COUNT reads flag 0.
        bus.i_instruction = 16'h0006;
        bus.i_flags = 3'b001;
        chk("sel3_f1_s0", FA, 0);
        chk("sel3_f1_s1", FB, 1);
        chk("sel3_f1_s2", 32'h21, 2);
        bus.i_flags = 3'b110;
        chk("sel3_f6_s0", FA, 0);
        chk("sel3_f6_s1", FB, 1);
        chk("sel3_f6_s2", 32'h21, 2);
        chk("sel3_f6_s3", 32'h22, 3);

        // Runaway guard with stalls.
        bus.i_instruction = 16'h003f;
        bus.i_flags = 3'b000;
        chk("ovf_s0", FA, 0);
        bus.i_stall = 1'b1;
        chk("stall_s1", 32'h0, 1);
        bus.i_stall = 1'b0;
        chk("ovf_s1", FB, 1);
        for (int s = 2; s < 5; s++) chk("ovf_run", 32'h0, s);
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) chk("stall_s5", 32'h0, 5);
        bus.i_stall = 1'b0;
        for (int s = 5; s < 31; s++) chk("ovf_run", 32'h0, s);
        bus.i_stall = 1'b1;
        chk("stall_s31", 32'h0, 31);
        bus.i_stall = 1'b0;
        chk_full("ovf_s31", 32'h0, 31, 0, 0, 1, 0);

        // HLT with END set: halt wins.
        bus.i_instruction = 16'h0005;
        chk("hlt_s0", FA, 0);
        chk("hlt_s1", FB, 1);
        chk("hlt_s2", 32'h11, 2);
        bus.i_stall = 1'b1;
        chk_full("halt_stall", 32'h0, 2, 1, 0, 0, 0);
        bus.i_stall = 1'b0;
        chk_full("halt_hold", 32'h0, 2, 1, 0, 0, 0);
        bus.i_stall  = 1'b1;
        bus.i_resume = 1'b1;
        chk_full("halt_resume", 32'h0, 2, 1, 0, 0, 0);
        bus.i_stall  = 1'b0;
        bus.i_resume = 1'b0;

        // Write to the addressed word while stalled, visible next cycle.
        bus.i_instruction = 16'h0007;
        chk("resume_s0", FA, 0);
        chk("wr_s1", FB, 1);
        bus.i_stall = 1'b1;
        bus.i_ucode_we = 1'b1;
        bus.i_ucode_addr = {6'h07, 5'd2};
        bus.i_ucode_data = mk(32'h41, 1, 0, 0, 0, 2'd0);
        chk("wr_stall_s2", 32'h0, 2);
        bus.i_stall = 1'b0;
        bus.i_ucode_we = 1'b0;
        chk("wr_new_s2", 32'h41, 2);

        // Asynchronous reset mid-instruction.
        bus.i_instruction = 16'h0001;
        chk("rst_s0", FA, 0);
        chk("rst_s1", FB, 1);
        chk("rst_s2", 32'h5, 2);
        rst = 1'b1;
        chk("rst_async", 32'h0, 0);
        rst = 1'b0;
        chk("rst_after_s0", FA, 0);
        chk("rst_after_s1", FB, 1);
        chk("rst_after_s2", 32'h5, 2);
        chk("rst_after_s3", 32'h9, 3);

`ifdef MICROCODE_SEQUENCER_PARITY_EN
        bus.i_instruction = 16'h0008;
        chk("par_s0", FA, 0);
        chk("par_s1", FB, 1);
        chk("par_s2", 32'h0, 2);
        chk_full("par_halt", 32'h0, 2, 1, 0, 0, 1);
        bus.i_resume = 1'b1;
        chk_full("par_resume", 32'h0, 2, 1, 0, 0, 1);
        bus.i_resume = 1'b0;
        bus.i_instruction = 16'h0001;
        chk_full("par_sticky", FA, 0, 0, 0, 0, 1);
        rst = 1'b1;
        chk("par_clear", 32'h0, 0);
        rst = 1'b0;
        chk("par_after", FA, 0);
`endif

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Loadable-microcode successor to the hard-coded instruction decoder. Owns the step counter and a writable microcode store indexed by {opcode, step}. Supports conditional early termination on any selectable ALU flag, halt/resume, stall, an illegal-opcode trap and a runaway-step guard. Sits between the instruction register/ALU flags and every bus-control input in the core.

## Interface
- INSTRUCTION_WIDTH, 16, instruction register width
- OPCODE_BITS, 6, decoded opcode bits; 2^OPCODE_BITS rows in the store
- INSTRUCTION_STEPS, 32, steps per instruction (power of 2); STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
- CONTROL_WORD_WIDTH, 32, control bus width
- FLAG_COUNT, 3, flag inputs; FSW = max(1, $clog2(FLAG_COUNT))
- FETCH0_CW, 0, control word driven at step 0
- FETCH1_CW, 0, control word driven at step 1
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_instruction  in  INSTRUCTION_WIDTH  current instruction register, valid from step 2
- i_flags  in  FLAG_COUNT  ALU flags
- i_stall  in  1  freeze sequencing
- i_resume  in  1  leave HALT
- i_ucode_we  in  1  microcode write strobe
- i_ucode_addr  in  OPCODE_BITS+STEP_WIDTH  write address {opcode, step}
- i_ucode_data  in  UW  microcode word; UW = CONTROL_WORD_WIDTH+4+FSW (+1 with parity)
- o_control_word  out  CONTROL_WORD_WIDTH  control bits
- o_step  out  STEP_WIDTH  current step
- o_halted  out  1  in HALT
- o_illegal  out  1  one-cycle pulse on an illegal opcode
- o_step_overflow  out  1  one-cycle pulse on a forced end
- o_ucode_error  out  1  sticky parity error (parity build only, else tied 0)

## Operation
- Word fields, LSB up: CTRL[CW-1:0], END, HLT, COND, POL, SEL[FSW-1:0], PAR (top, parity build only).
- States: RUN, HALT. Reset: RUN, step 0, all outputs 0. The store is not cleared by reset.
- Steps 0/1 drive FETCH0_CW/FETCH1_CW and ignore the store. Step >= 2 reads the store combinationally at {i_instruction[OPCODE_BITS-1:0], step}.
- Illegal opcode: any of i_instruction[INSTRUCTION_WIDTH-1:OPCODE_BITS] nonzero. Treated as a NOP at step 2: CTRL output 0, ends, o_illegal=1.
- End condition at step >= 2 is END | (COND & (i_flags[SEL]==POL)). Conditional end suppresses nothing else: CTRL is still driven that cycle. SEL >= FLAG_COUNT reads as flag 0.
- Runaway guard: step == INSTRUCTION_STEPS-1 without an end condition forces an end, o_step_overflow=1.
- HLT at step >= 2 drives CTRL that cycle, then enters HALT. HLT has priority over END.
- HALT: step holds, o_control_word=0, o_halted=1. i_resume makes the next state RUN with step 0.
- Stall in RUN: step holds, o_control_word=0, no pulses, no state change. Stall has no effect in HALT.
- Writes are accepted in any state. A write to the currently addressed word is visible from the next cycle.

## Timing
- Control word is combinational from step/instruction/flags/store: 0-cycle latency.
- Step advances on each rising edge in RUN without stall: ending → 0, otherwise +1.
- o_illegal and o_step_overflow are combinational and valid in the cycle of the event.
- Asserting i_reset mid-instruction forces step 0/RUN immediately. Outputs are 0 while i_reset is high.
- i_resume and i_stall sampled together in HALT: resume wins.

## Configuration
- MICROCODE_SEQUENCER_PARITY_EN defined:
  - PAR bit present; even parity over all other fields.
  - A mismatch on a read word at step >= 2 sets sticky o_ucode_error (cleared by reset only) and enters HALT with CTRL=0 that cycle.
- Undefined: no PAR bit, o_ucode_error=0.

## Test plan
- Load opcode 0x01 steps 2,3 = {CTRL=0x5}, {CTRL=0x9, END}; instruction 0x0001 → step sequence 0,1,2,3,0; CW FETCH0,FETCH1,0x5,0x9.
- Opcode 0x2e step 2 = {CTRL=0x3, COND, POL=0, SEL=0}, step 3 = END; i_flags[0]=1 → step 3 reached; i_flags[0]=0 → step 2 returns to 0.
- Instruction 0xffc0 (illegal) → step 2 CW=0, o_illegal=1, next step 0.
- Opcode 0x3f rows zero → o_step_overflow=1 at step 31, then step 0. Assert i_stall at step 5 for 3 cycles → step stays 5, CW=0.
- HLT word at step 2 → CW driven, next cycle o_halted=1, CW=0. i_resume → step 0. Reset at step 3 → step 0 asynchronously.
- Parity build: write a word with bad PAR, execute → o_ucode_error=1, o_halted=1, sticky until i_reset.
